// File: rtl/shift_serializer.sv
// rtl/shift_serializer.sv - parallel-in, serial-out word transmitter, MSB first, with optional inter-word gap
module shift_serializer #(
  parameter int WIDTH    = 3,
  parameter int IDLE_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);
  localparam logic HAS_GAP = (IDLE_GAP > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             load;

  // Next-state, ready and registered-output precomputation; the word bit
  // shown in a cycle is the MSB of the shift register for that cycle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    in_ready  = 1'b0;
    load      = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        SHIFT:   in_ready = (bit_cnt_q == '0) && !HAS_GAP;
        GAP:     in_ready = (gap_cnt_q == '0);
        default: in_ready = 1'b0;
      endcase
    end

    accept = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt_q != '0) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - BW'(1);
        end else if (accept) begin
          load = 1'b1;
        end else if (HAS_GAP) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d   = SHIFT;
      shreg_d   = in_data;
      bit_cnt_d = BIT_LOAD;
    end

    ser_valid_d = (state_d == SHIFT);
    ser_data_d  = ser_valid_d && shreg_d[WIDTH-1];
    ser_last_d  = ser_valid_d && (bit_cnt_d == '0);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers; reset aborts any word or gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_serializer.sv
// tb/tb_shift_serializer.sv - table, directed and random checks of shift_serializer with gap 0 and gap 2
module tb_shift_serializer;

  localparam int W  = 3;
  localparam int G2 = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;

  logic in_ready0, ser_data0, ser_valid0, ser_last0, busy0;
  logic in_ready2, ser_data2, ser_valid2, ser_last2, busy2;

  logic [W-1:0] rx0, rx2;

  int total;
  int bad;
  int cyc;

  int           acc_n[2];
  int           ready_from[2];
  bit           have_word[2];
  logic [W-1:0] word[2];
  bit           rx_pend[2];
  logic [W-1:0] rx_word[2];

  shift_serializer #(.WIDTH(W), .IDLE_GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .ser_data(ser_data0), .ser_valid(ser_valid0), .ser_last(ser_last0), .busy(busy0)
  );

  shift_serializer #(.WIDTH(W), .IDLE_GAP(G2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .ser_data(ser_data2), .ser_valid(ser_valid2), .ser_last(ser_last2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver side: 3-bit shift register fed by the serial link.
  always @(posedge clk) begin
    if (ser_valid0) rx0 <= {rx0[W-2:0], ser_data0};
    if (ser_valid2) rx2 <= {rx2[W-2:0], ser_data2};
  end

  typedef struct packed {
    logic         r;
    logic         v;
    logic [W-1:0] d;
    logic [4:0]   e0;
    logic [4:0]   e2;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input int c, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b ({ready,valid,data,last,busy})", name, c, act, exp);
    end
  endtask

  function automatic logic [4:0] model_exp(input int k, input int c, input logic r);
    int   g;
    int   off;
    logic rdy, v, d, l, b;
    g   = (k == 0) ? 0 : G2;
    rdy = !r && (c >= ready_from[k]);
    v = 1'b0; d = 1'b0; l = 1'b0; b = 1'b0;
    if (have_word[k]) begin
      off = c - acc_n[k];
      v   = (off >= 1) && (off <= W);
      if (v) d = word[k][W-off];
      l   = (off == W);
      b   = (off >= 1) && (off <= W + g);
    end
    return {rdy, v, d, l, b};
  endfunction

  task automatic model_update(input int k, input int c, input logic r, input logic v, input logic [W-1:0] d);
    int g;
    g = (k == 0) ? 0 : G2;
    if (!r && have_word[k] && (c - acc_n[k] == W)) begin
      rx_pend[k] = 1'b1;
      rx_word[k] = word[k];
    end
    if (r) begin
      have_word[k]  = 1'b0;
      ready_from[k] = c + 1;
      rx_pend[k]    = 1'b0;
    end else if (v && (c >= ready_from[k])) begin
      have_word[k]  = 1'b1;
      acc_n[k]      = c;
      word[k]       = d;
      ready_from[k] = c + W + g;
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [W-1:0] d,
                      input logic has_exp, input logic [4:0] e0, input logic [4:0] e2);
    logic [4:0] a0, a2;
    rst = r; in_valid = v; in_data = d;
    @(negedge clk);
    a0 = {in_ready0, ser_valid0, ser_data0, ser_last0, busy0};
    a2 = {in_ready2, ser_valid2, ser_data2, ser_last2, busy2};
    chk("model_gap0", cyc, a0, model_exp(0, cyc, r));
    chk("model_gap2", cyc, a2, model_exp(1, cyc, r));
    if (rx_pend[0]) begin
      chk("rx_out_gap0", cyc, {2'b00, rx0}, {2'b00, rx_word[0]});
      rx_pend[0] = 1'b0;
    end
    if (rx_pend[1]) begin
      chk("rx_out_gap2", cyc, {2'b00, rx2}, {2'b00, rx_word[1]});
      rx_pend[1] = 1'b0;
    end
    if (has_exp) begin
      chk("table_gap0", cyc, a0, e0);
      chk("table_gap2", cyc, a2, e2);
    end
    @(posedge clk);
    model_update(0, cyc, r, v, d);
    model_update(1, cyc, r, v, d);
    cyc++;
    #1;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      acc_n[k] = 0; ready_from[k] = 0; have_word[k] = 1'b0;
      word[k] = '0; rx_pend[k] = 1'b0; rx_word[k] = '0;
    end

    //            rst   v     d       gap0      gap2
    tbl[0]  = '{1'b1, 1'b1, 3'b111, 5'b00000, 5'b00000};
    tbl[1]  = '{1'b1, 1'b1, 3'b111, 5'b00000, 5'b00000};
    tbl[2]  = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b10000};
    tbl[3]  = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b10000};
    tbl[4]  = '{1'b0, 1'b1, 3'b101, 5'b10000, 5'b10000};
    tbl[5]  = '{1'b0, 1'b0, 3'b010, 5'b01101, 5'b01101};
    tbl[6]  = '{1'b0, 1'b0, 3'b000, 5'b01001, 5'b01001};
    tbl[7]  = '{1'b0, 1'b0, 3'b000, 5'b11111, 5'b01111};
    tbl[8]  = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b00001};
    tbl[9]  = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b10001};
    tbl[10] = '{1'b0, 1'b1, 3'b110, 5'b10000, 5'b10000};
    tbl[11] = '{1'b0, 1'b1, 3'b011, 5'b01101, 5'b01101};
    tbl[12] = '{1'b0, 1'b1, 3'b011, 5'b01101, 5'b01101};
    tbl[13] = '{1'b0, 1'b1, 3'b011, 5'b11011, 5'b01011};
    tbl[14] = '{1'b0, 1'b1, 3'b011, 5'b01001, 5'b00001};
    tbl[15] = '{1'b0, 1'b1, 3'b011, 5'b01101, 5'b10001};
    tbl[16] = '{1'b0, 1'b0, 3'b000, 5'b11111, 5'b01001};
    tbl[17] = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b01101};
    tbl[18] = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b01111};
    tbl[19] = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b00001};
    tbl[20] = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b10001};
    tbl[21] = '{1'b0, 1'b0, 3'b000, 5'b10000, 5'b10000};

    rst = 1'b1; in_valid = 1'b1; in_data = 3'b111;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++)
      tick(tbl[i].r, tbl[i].v, tbl[i].d, 1'b1, tbl[i].e0, tbl[i].e2);

    // Reset during the second bit of 3'b010, then 3'b100 with clean framing.
    tick(1'b0, 1'b1, 3'b010, 1'b0, 5'b0, 5'b0);
    tick(1'b0, 1'b0, 3'b000, 1'b0, 5'b0, 5'b0);
    tick(1'b1, 1'b0, 3'b000, 1'b1, 5'b01101, 5'b01101);
    tick(1'b0, 1'b1, 3'b100, 1'b1, 5'b10000, 5'b10000);
    tick(1'b0, 1'b0, 3'b000, 1'b1, 5'b01101, 5'b01101);
    tick(1'b0, 1'b0, 3'b000, 1'b1, 5'b01001, 5'b01001);
    tick(1'b0, 1'b0, 3'b000, 1'b1, 5'b11011, 5'b01011);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 3'b000, 1'b0, 5'b0, 5'b0);

    // Source held valid with in_data changing every cycle: stalls and capture.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] d;
      d = W'($urandom_range(0, 7));
      tick(1'b0, 1'b1, d, 1'b0, 5'b0, 5'b0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic         r, v;
      logic [W-1:0] d;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = W'($urandom_range(0, 7));
      tick(r, v, d, 1'b0, 5'b0, 5'b0);
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 3'b000, 1'b0, 5'b0, 5'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
